ahb_manager_desc_seq: RTL and testbench

- Descriptor sequencer directly upstream of the AHB manager top-level user interface (UI).
- Accepts one burst descriptor at a time: base address, beat count, size, direction.
- Drives the manager's UI command/write-data inputs beat by beat, honouring the manager's stall.
- Counts in-order read responses and signals completion, so software/DMA logic deals only with descriptors.

---
 rtl/ahb_manager_pack.sv | 29 ++
 rtl/ahb_manager_desc_seq_if.sv | 31 +++
 rtl/ahb_desc_seq_rsp_ctr.sv | 57 +++++
 rtl/ahb_manager_desc_seq.sv | 140 ++++++++++++++
 tb/tb_ahb_manager_desc_seq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_manager_pack.sv
// Shared AHB manager types: transfer size, descriptor sequencer state and the
// registered burst descriptor.
package ahb_manager_pack;

    localparam int DESC_ADDR_WDT = 32;
    localparam int DESC_LEN_WDT  = 32;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } t_hsize;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_XFER,
        DS_DRAIN,
        DS_DONE
    } t_desc_seq_state;

    typedef struct packed {
        logic [DESC_ADDR_WDT-1:0] addr;
        logic [DESC_LEN_WDT-1:0]  len;
        t_hsize                   size;
        logic                     wr;
    } t_ahb_desc;

endpackage

// File: rtl/ahb_manager_desc_seq_if.sv
// Sequencer <-> AHB manager user-interface bundle (command, write data, stall,
// read response). The master modport is the sequencer side.
interface ahb_manager_desc_seq_if #(
    parameter int DATA_WDT = 32,
    parameter int BEAT_WDT = 32
);
    logic                          o_idle;
    logic                          o_first_xfer;
    logic                          o_wr;
    logic                          o_rd;
    logic                          o_wr_data_dav;
    logic [31:0]                   o_addr;
    ahb_manager_pack::t_hsize      o_size;
    logic [BEAT_WDT-1:0]           o_min_len;
    logic [DATA_WDT-1:0]           o_wr_data;
    logic                          i_stall;
    logic [DATA_WDT-1:0]           i_rdata;
    logic                          i_rdav;

    modport master (
        output o_idle, o_first_xfer, o_wr, o_rd, o_wr_data_dav,
        output o_addr, o_size, o_min_len, o_wr_data,
        input  i_stall, i_rdata, i_rdav
    );

    modport slave (
        input  o_idle, o_first_xfer, o_wr, o_rd, o_wr_data_dav,
        input  o_addr, o_size, o_min_len, o_wr_data,
        output i_stall, i_rdata, i_rdav
    );
endinterface

// File: rtl/ahb_desc_seq_rsp_ctr.sv
// Read response path: registers manager read data and counts responses.
// With AHB_DESC_SEQ_RD_CREDIT_EN it also reports outstanding read beats.
module ahb_desc_seq_rsp_ctr #(
    parameter int DATA_WDT = 32,
    parameter int BEAT_WDT = 32
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_clr,
    input  logic                i_cnt_en,
    input  logic [DATA_WDT-1:0] i_rdata,
    input  logic                i_rdav,
`ifdef AHB_DESC_SEQ_RD_CREDIT_EN
    input  logic [BEAT_WDT-1:0] i_issue_cnt,
    output logic [BEAT_WDT-1:0] o_outstanding,
`endif
    output logic [DATA_WDT-1:0] o_rdata,
    output logic                o_rvalid,
    output logic [BEAT_WDT-1:0] o_rsp_cnt_d
);
    logic [BEAT_WDT-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [DATA_WDT-1:0] rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    // A new descriptor clears the count even if a stray response lands that cycle.
    always_comb begin
        rsp_cnt_d = rsp_cnt_q;
        rdata_d   = i_rdata;
        rvalid_d  = i_rdav;
        if (i_clr) begin
            rsp_cnt_d = '0;
        end else if (i_cnt_en && i_rdav && (rsp_cnt_q != '1)) begin
            rsp_cnt_d = rsp_cnt_q + BEAT_WDT'(1);
        end
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            rsp_cnt_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            rsp_cnt_q <= rsp_cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

`ifdef AHB_DESC_SEQ_RD_CREDIT_EN
    assign o_outstanding = (i_issue_cnt >= rsp_cnt_q) ? (i_issue_cnt - rsp_cnt_q) : '0;
`endif

    assign o_rdata     = rdata_q;
    assign o_rvalid    = rvalid_q;
    assign o_rsp_cnt_d = rsp_cnt_d;

endmodule

// File: rtl/ahb_manager_desc_seq.sv
// Descriptor sequencer feeding the AHB manager UI one beat at a time.
// Optional macro AHB_DESC_SEQ_RD_CREDIT_EN limits outstanding read beats to RD_CREDITS.
module ahb_manager_desc_seq
    import ahb_manager_pack::*;
#(
    parameter int DATA_WDT   = 32,
    parameter int BEAT_WDT   = 32,
    parameter int RD_CREDITS = 4
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic                  i_desc_valid,
    output logic                  o_desc_ready,
    input  logic [31:0]           i_desc_addr,
    input  logic [BEAT_WDT-1:0]   i_desc_len,
    input  t_hsize                i_desc_size,
    input  logic                  i_desc_wr,
    input  logic [DATA_WDT-1:0]   i_wdata,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    ahb_manager_desc_seq_if.master ui,
    output logic [DATA_WDT-1:0]   o_rdata,
    output logic                  o_rvalid,
    output logic                  o_done,
    output logic                  o_busy
);
    t_desc_seq_state     state_q, state_d;
    t_ahb_desc           desc_q, desc_d;
    logic [BEAT_WDT-1:0] issue_q, issue_d;
    logic [BEAT_WDT-1:0] rsp_cnt_d;
    logic [BEAT_WDT-1:0] len_cur;
    logic                in_xfer, rd_gate, rd_cmd, wr_cmd, beat_acc, last_beat, rsp_clr;

    assign len_cur = BEAT_WDT'(desc_q.len);
    assign in_xfer = (state_q == DS_XFER);

`ifdef AHB_DESC_SEQ_RD_CREDIT_EN
    logic [BEAT_WDT-1:0] outstanding;
    assign rd_gate = (outstanding < BEAT_WDT'(RD_CREDITS));
`else
    assign rd_gate = 1'b1;
`endif

    assign rd_cmd    = in_xfer && !desc_q.wr && (issue_q < len_cur) && rd_gate;
    assign wr_cmd    = in_xfer && desc_q.wr;
    assign beat_acc  = !ui.i_stall && (rd_cmd || (wr_cmd && i_wvalid));
    assign last_beat = beat_acc && (issue_q == (len_cur - BEAT_WDT'(1)));

    // Next-state logic; a zero-length descriptor goes straight to DONE with no UI activity.
    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        issue_d = issue_q;
        rsp_clr = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (i_desc_valid) begin
                    desc_d.addr = i_desc_addr;
                    desc_d.len  = DESC_LEN_WDT'(i_desc_len);
                    desc_d.size = i_desc_size;
                    desc_d.wr   = i_desc_wr;
                    issue_d     = '0;
                    rsp_clr     = 1'b1;
                    state_d     = (i_desc_len == '0) ? DS_DONE : DS_XFER;
                end
            end
            DS_XFER: begin
                if (beat_acc) begin
                    issue_d = issue_q + BEAT_WDT'(1);
                end
                if (last_beat) begin
                    if (desc_q.wr || (rsp_cnt_d == len_cur)) begin
                        state_d = DS_DONE;
                    end else begin
                        state_d = DS_DRAIN;
                    end
                end
            end
            DS_DRAIN: begin
                if (rsp_cnt_d == len_cur) begin
                    state_d = DS_DONE;
                end
            end
            DS_DONE: begin
                state_d = DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_q <= DS_IDLE;
            desc_q  <= '0;
            issue_q <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            issue_q <= issue_d;
        end
    end

    ahb_desc_seq_rsp_ctr #(
        .DATA_WDT (DATA_WDT),
        .BEAT_WDT (BEAT_WDT)
    ) u_rsp_ctr (
        .i_hclk        (i_hclk),
        .i_hreset      (i_hreset),
        .i_clr         (rsp_clr),
        .i_cnt_en      (!desc_q.wr),
        .i_rdata       (ui.i_rdata),
        .i_rdav        (ui.i_rdav),
`ifdef AHB_DESC_SEQ_RD_CREDIT_EN
        .i_issue_cnt   (issue_q),
        .o_outstanding (outstanding),
`endif
        .o_rdata       (o_rdata),
        .o_rvalid      (o_rvalid),
        .o_rsp_cnt_d   (rsp_cnt_d)
    );

    // Command fields come straight from the descriptor register, so they cannot move under stall.
    assign ui.o_idle        = !in_xfer;
    assign ui.o_first_xfer  = in_xfer && (issue_q == '0);
    assign ui.o_rd          = rd_cmd;
    assign ui.o_wr          = wr_cmd;
    assign ui.o_wr_data_dav = wr_cmd && i_wvalid;
    assign ui.o_wr_data     = wr_cmd ? i_wdata : '0;
    assign ui.o_addr        = desc_q.addr;
    assign ui.o_size        = desc_q.size;
    assign ui.o_min_len     = len_cur;

    assign o_wready     = wr_cmd && i_wvalid && !ui.i_stall;
    assign o_desc_ready = (state_q == DS_IDLE);
    assign o_busy       = (state_q != DS_IDLE);
    assign o_done       = (state_q == DS_DONE);

endmodule

// File: tb/tb_ahb_manager_desc_seq.sv
// Directed self-checking bench for ahb_manager_desc_seq; inputs change 1ns after
// the rising edge and outputs are compared 2ns later.
module tb_ahb_manager_desc_seq;
    import ahb_manager_pack::*;

    localparam int DATA_WDT = 32;
    localparam int BEAT_WDT = 32;
`ifdef AHB_DESC_SEQ_RD_CREDIT_EN
    localparam int RD_CREDITS = 2;
`else
    localparam int RD_CREDITS = 4;
`endif

    logic                i_hclk = 1'b0;
    logic                i_hreset;
    logic                i_desc_valid;
    logic                o_desc_ready;
    logic [31:0]         i_desc_addr;
    logic [BEAT_WDT-1:0] i_desc_len;
    t_hsize              i_desc_size;
    logic                i_desc_wr;
    logic [DATA_WDT-1:0] i_wdata;
    logic                i_wvalid;
    logic                o_wready;
    logic [DATA_WDT-1:0] o_rdata;
    logic                o_rvalid;
    logic                o_done;
    logic                o_busy;

    ahb_manager_desc_seq_if #(.DATA_WDT(DATA_WDT), .BEAT_WDT(BEAT_WDT)) ui ();

    ahb_manager_desc_seq #(
        .DATA_WDT   (DATA_WDT),
        .BEAT_WDT   (BEAT_WDT),
        .RD_CREDITS (RD_CREDITS)
    ) dut (
        .i_hclk       (i_hclk),
        .i_hreset     (i_hreset),
        .i_desc_valid (i_desc_valid),
        .o_desc_ready (o_desc_ready),
        .i_desc_addr  (i_desc_addr),
        .i_desc_len   (i_desc_len),
        .i_desc_size  (i_desc_size),
        .i_desc_wr    (i_desc_wr),
        .i_wdata      (i_wdata),
        .i_wvalid     (i_wvalid),
        .o_wready     (o_wready),
        .ui           (ui),
        .o_rdata      (o_rdata),
        .o_rvalid     (o_rvalid),
        .o_done       (o_done),
        .o_busy       (o_busy)
    );

    always #5 i_hclk = ~i_hclk;

    int checks   = 0;
    int failures = 0;

    logic       rdav_tab [16];
    logic [6:0] rexp_tab [16];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic dvalid, input logic [31:0] addr, input logic [31:0] len,
                                 input t_hsize size, input logic wr, input logic wvalid,
                                 input logic [31:0] wdata, input logic stall, input logic rdav,
                                 input logic [31:0] rdata);
        i_desc_valid = dvalid;
        i_desc_addr  = addr;
        i_desc_len   = len;
        i_desc_size  = size;
        i_desc_wr    = wr;
        i_wvalid     = wvalid;
        i_wdata      = wdata;
        ui.i_stall   = stall;
        ui.i_rdav    = rdav;
        ui.i_rdata   = rdata;
    endtask

    task automatic nextCycle();
        @(posedge i_hclk);
        #1;
    endtask

    // Read burst driven from rdav_tab; each cycle is checked against rexp_tab
    // packed as {ready, busy, idle, first_xfer, rd, rvalid, done}.
    task automatic runReadTable(input string name, input logic [31:0] addr, input logic [31:0] len, input int ncyc);
        logic [6:0] obs;
        for (int k = 0; k < ncyc; k++) begin
            applyStimulus(k == 0, addr, len, HSIZE_WORD, 1'b0, 1'b0, 32'h0, 1'b0, rdav_tab[k], 32'hD000_0000 + k);
            #2;
            obs = {o_desc_ready, o_busy, ui.o_idle, ui.o_first_xfer, ui.o_rd, o_rvalid, o_done};
            checkOutput($sformatf("%s_c%0d", name, k), {57'h0, obs}, {57'h0, rexp_tab[k]});
            if (rexp_tab[k][1]) begin
                checkOutput($sformatf("%s_rdata_c%0d", name, k), {32'h0, o_rdata}, {32'h0, 32'hD000_0000 + k - 1});
            end
            if (k == 1) begin
                checkOutput($sformatf("%s_addr", name), {32'h0, ui.o_addr}, {32'h0, addr});
                checkOutput($sformatf("%s_min_len", name), {32'h0, ui.o_min_len}, {32'h0, len});
                checkOutput($sformatf("%s_size", name), {61'h0, ui.o_size}, {61'h0, HSIZE_WORD});
            end
            nextCycle();
        end
    endtask

    task automatic loadRead4();
        for (int k = 0; k < 16; k++) begin
            rdav_tab[k] = 1'b0;
            rexp_tab[k] = 7'b1010000;
        end
        rdav_tab[3] = 1'b1; rdav_tab[4] = 1'b1; rdav_tab[5] = 1'b1; rdav_tab[6] = 1'b1;
        rexp_tab[0] = 7'b1010000;
        rexp_tab[1] = 7'b0101100;
        rexp_tab[2] = 7'b0100100;
        rexp_tab[3] = 7'b0100100;
        rexp_tab[4] = 7'b0100110;
        rexp_tab[5] = 7'b0110010;
        rexp_tab[6] = 7'b0110010;
        rexp_tab[7] = 7'b0110011;
        rexp_tab[8] = 7'b1010000;
    endtask

    initial begin
        logic [7:0]  wexp_tab [8];
        logic        wval_tab [8];
        logic        wstl_tab [8];
        logic [31:0] wdat_tab [8];
        logic [7:0]  wobs;
        int          wready_cnt;

        applyStimulus(1'b0, 32'h0, 32'h0, HSIZE_BYTE, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        i_hreset = 1'b0;
        #1 i_hreset = 1'b1;
        #2;
        checkOutput("rst_ctrl", {58'h0, o_desc_ready, o_busy, ui.o_idle, ui.o_rd, ui.o_wr, o_done}, {58'h0, 6'b101000});
        checkOutput("rst_size", {61'h0, ui.o_size}, 64'h0);
        checkOutput("rst_rvalid", {63'h0, o_rvalid}, 64'h0);
        @(posedge i_hclk);
        @(posedge i_hclk);
        #1 i_hreset = 1'b0;
        nextCycle();

        $display("[TB] read burst len=4");
        loadRead4();
        runReadTable("rd4", 32'h0000_1000, 32'd4, 9);

        $display("[TB] write burst len=3 with gaps and stall");
        wval_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        wstl_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        wdat_tab = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h33, 32'h44, 32'h0, 32'h0};
        wexp_tab = '{8'b1010_0000, 8'b0101_1110, 8'b0100_1000, 8'b0100_1100,
                     8'b0100_1110, 8'b0100_1110, 8'b0110_0001, 8'b1010_0000};
        wready_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(k == 0, 32'h0000_2000, 32'd3, HSIZE_WORD, 1'b1, wval_tab[k], wdat_tab[k], wstl_tab[k], 1'b0, 32'h0);
            #2;
            wobs = {o_desc_ready, o_busy, ui.o_idle, ui.o_first_xfer, ui.o_wr, ui.o_wr_data_dav, o_wready, o_done};
            checkOutput($sformatf("wr3_c%0d", k), {56'h0, wobs}, {56'h0, wexp_tab[k]});
            if (wexp_tab[k][2]) begin
                checkOutput($sformatf("wr3_wdata_c%0d", k), {32'h0, ui.o_wr_data}, {32'h0, wdat_tab[k]});
            end
            if (k == 3) begin
                checkOutput("wr3_stall_addr", {32'h0, ui.o_addr}, 64'h2000);
                checkOutput("wr3_stall_len", {32'h0, ui.o_min_len}, 64'd3);
            end
            if (o_wready) wready_cnt++;
            nextCycle();
        end
        checkOutput("wr3_wready_cnt", 64'(wready_cnt), 64'd3);

        $display("[TB] zero-length descriptor");
        applyStimulus(1'b1, 32'h0000_3000, 32'd0, HSIZE_WORD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("len0_c0", {58'h0, o_desc_ready, o_busy, ui.o_idle, ui.o_rd, ui.o_wr, o_done}, {58'h0, 6'b101000});
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'd0, HSIZE_BYTE, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("len0_c1", {58'h0, o_desc_ready, o_busy, ui.o_idle, ui.o_rd, ui.o_wr, o_done}, {58'h0, 6'b011001});
        nextCycle();
        #2;
        checkOutput("len0_c2", {58'h0, o_desc_ready, o_busy, ui.o_idle, ui.o_rd, ui.o_wr, o_done}, {58'h0, 6'b101000});
        nextCycle();

        $display("[TB] reset in the middle of a read burst");
        applyStimulus(1'b1, 32'h0000_4000, 32'd8, HSIZE_HALF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0000_4000, 32'd8, HSIZE_HALF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("mid_rd_before_rst", {62'h0, ui.o_rd, ui.o_first_xfer}, {62'h0, 2'b10});
        i_hreset = 1'b1;
        #1;
        checkOutput("mid_rst_ctrl", {58'h0, o_desc_ready, o_busy, ui.o_idle, ui.o_rd, ui.o_first_xfer, o_done}, {58'h0, 6'b101000});
        checkOutput("mid_rst_fields", {ui.o_addr, ui.o_min_len}, 64'h0);
        checkOutput("mid_rst_size", {61'h0, ui.o_size}, 64'h0);
        @(posedge i_hclk);
        #1 i_hreset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            checkOutput($sformatf("post_rst_quiet_c%0d", k), {62'h0, o_done, o_busy}, 64'h0);
            nextCycle();
        end
        loadRead4();
        runReadTable("rd_after_rst", 32'h0000_5000, 32'd4, 9);

        $display("[TB] response on the last issue cycle");
        for (int k = 0; k < 16; k++) begin
            rdav_tab[k] = 1'b0;
            rexp_tab[k] = 7'b1010000;
        end
        rdav_tab[1] = 1'b1; rdav_tab[2] = 1'b1;
        rexp_tab[1] = 7'b0101100;
        rexp_tab[2] = 7'b0100110;
        rexp_tab[3] = 7'b0110011;
        runReadTable("rd_same", 32'h0000_6000, 32'd2, 7);

`ifdef AHB_DESC_SEQ_RD_CREDIT_EN
        begin
            int due_q [$];
            int issued, responded, max_out, done_seen, cyc;
            logic rdav_now;
            $display("[TB] credit-limited read len=6");
            issued = 0; responded = 0; max_out = 0; done_seen = 0;
            cyc = 0;
            while (cyc < 200 && done_seen == 0) begin
                rdav_now = (due_q.size() != 0) && (due_q[0] == cyc);
                if (rdav_now) begin
                    void'(due_q.pop_front());
                    responded++;
                end
                applyStimulus(cyc == 0, 32'h0000_7000, 32'd6, HSIZE_WORD, 1'b0, 1'b0, 32'h0, 1'b0, rdav_now, 32'h0);
                #2;
                if (ui.o_rd) begin
                    issued++;
                    due_q.push_back(cyc + 5);
                end
                if ((issued - responded) > max_out) max_out = issued - responded;
                if (o_done) done_seen = 1;
                nextCycle();
                cyc++;
            end
            checkOutput("credit_max_outstanding", 64'(max_out), 64'd2);
            checkOutput("credit_beats_issued", 64'(issued), 64'd6);
            checkOutput("credit_done_seen", 64'(done_seen), 64'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
